imem_loadable: RTL and testbench
================================

IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 9, meaning byte-address width; depth = 2**(INS_ADDRESS-2) words.
REQ-002 SHALL have parameter INS_W, default 32, meaning instruction word width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ld_valid  input  1  the loader offers a program word.
REQ-006 SHALL have port ld_data  input  INS_W  the program word to store.
REQ-007 SHALL have port ld_last  input  1  marks the final program word.
REQ-008 SHALL have port ld_ready  output  1  the block accepts a load word this cycle.
REQ-009 SHALL have port fe_req  input  1  fetch request.
REQ-010 SHALL have port ra  input  INS_ADDRESS  fetch byte address from the PC.
REQ-011 SHALL have port fe_ready  output  1  a fetch is accepted this cycle.
REQ-012 SHALL have port rd  output  INS_W  the fetched instruction, registered.
REQ-013 SHALL have port rd_valid  output  1  rd holds a response this cycle.
REQ-014 SHALL have port fault  output  1  the response at rd is a misaligned fetch; qualified by rd_valid.

Function
REQ-015 SHALL implement the states LOAD and RUN; reset enters LOAD.
REQ-016 SHALL, in LOAD, drive ld_ready=1 and fe_ready=0.
REQ-017 SHALL, on each ld_valid&&ld_ready, write ld_data to word index wptr, then increment wptr.
REQ-018 SHALL move LOAD->RUN on an accepted word with ld_last=1, or on an accepted write to word DEPTH-1; wptr does not wrap.
REQ-019 SHALL, in RUN, drive ld_ready=0 and fe_ready=1, and ignore ld_valid.
REQ-020 SHALL, on fe_req&&fe_ready, read word ra[INS_ADDRESS-1:2] and present it on rd with rd_valid=1 exactly one cycle later; back-to-back fetches give one response per cycle.
REQ-021 SHALL, when ra[1:0]!=0, return rd=0 and fault=1 alongside rd_valid.
REQ-022 SHALL hold rd at its last value, with rd_valid=0 and fault=0, in cycles following no accepted fetch.
REQ-023 SHALL return the content written by the loader for any word at or below the final wptr; unwritten words return 0.

Reset
REQ-024 SHALL, on reset, force state=LOAD, wptr=0, rd=0, rd_valid=0, fault=0, ld_ready=1, fe_ready=0.
REQ-025 SHALL, on reset, clear every word to 0 over the reset cycle through a valid-bit vector (no multi-cycle clear), and abort any load or fetch in flight.
REQ-026 SHALL give reset priority over simultaneous ld_valid and fe_req.

Configuration
REQ-027 SHALL support macro IMEM_PARITY_EN; when defined, each word stores an even-parity bit computed at load, and a fetch whose recomputed parity mismatches sets fault=1 with rd equal to the stored data.
REQ-028 SHALL, without IMEM_PARITY_EN, store no parity bits, and fault reports only misalignment.

Structure
REQ-029 SHALL place the state enum (LOAD, RUN) and the NOP constant 32'h00000013 in the shared package imem_pkg.
REQ-030 SHALL contain the storage array plus valid bits as one sub-module, imem_array (one write port, one registered read port).

Verification
REQ-031 SHALL cover: load 32'h00100093, 32'h00200113 (last) -> RUN after the 2nd accept; fetch ra=4 -> rd=32'h00200113, rd_valid=1 one cycle later.
REQ-032 SHALL cover: fetch ra=0,4,8 on consecutive cycles -> rd sequence 32'h00100093, 32'h00200113, 0 with rd_valid high 3 cycles.
REQ-033 SHALL cover: fetch ra=6 -> rd=0, fault=1, rd_valid=1.
REQ-034 SHALL cover: load 128 words without ld_last -> RUN after word 127; fetch ra=508 returns word 127.
REQ-035 SHALL cover: reset asserted mid-load after 3 words -> LOAD, wptr=0; fetch of ra=0 after a 1-word reload returns the new word.
REQ-036 SHALL cover: fe_req held during LOAD -> fe_ready=0 and no rd_valid until RUN.

Source files
------------

// File: rtl/imem_pkg.sv
// +--------------------------------------------------------------------+
// | imem_pkg : shared state encoding and constants for imem_loadable    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package imem_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [31:0] NOP = 32'h00000013;

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// +--------------------------------------------------------------------+
// | imem_array : word storage with per-word valid bits, one write port  |
// | and one registered read port. Optional parity via IMEM_PARITY_EN.   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module imem_array
  import imem_pkg::*;
#(
  parameter int AW = 7,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic          rzero_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o,
  output logic          perr_o
);

  localparam int DEPTH = 2 ** AW;
`ifdef IMEM_PARITY_EN
  localparam int MW = W + 1;
`else
  localparam int MW = W;
`endif

  logic [MW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [MW-1:0]    rword_q;
  logic [MW-1:0]    wword;

`ifdef IMEM_PARITY_EN
  // Even parity: the stored word including its parity bit XORs to zero.
  assign wword  = {^wdata_i, wdata_i};
  assign perr_o = ^rword_q;
`else
  assign wword  = wdata_i;
  assign perr_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wword;
    end
  end

  // Clearing the valid vector makes every word read as zero after one reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      rword_q <= '0;
    end else begin
      if (we_i) begin
        valid_q[waddr_i] <= 1'b1;
      end
      if (re_i) begin
        rword_q <= (rzero_i || !valid_q[raddr_i]) ? '0 : mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rword_q[W-1:0];

endmodule

`default_nettype wire

// File: rtl/imem_loadable.sv
// +--------------------------------------------------------------------+
// | imem_loadable : instruction memory filled by a streaming loader,    |
// | then serving fetches. Optional parity check via IMEM_PARITY_EN.     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module imem_loadable
  import imem_pkg::*;
#(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  input  logic [INS_W-1:0]       ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  input  logic                   fe_req,
  input  logic [INS_ADDRESS-1:0] ra,
  output logic                   fe_ready,
  output logic [INS_W-1:0]       rd,
  output logic                   rd_valid,
  output logic                   fault
);

  localparam int             WAW   = INS_ADDRESS - 2;
  localparam logic [WAW-1:0] WLAST = '1;

  state_e         state_q;
  logic [WAW-1:0] wptr_q;
  logic           rd_valid_q;
  logic           misalign_q;
  logic           ld_acc;
  logic           fe_acc;
  logic           perr;

  assign ld_ready = (state_q == LOAD);
  assign fe_ready = (state_q == RUN);

  // Reset masks both handshakes so nothing is written or read on a reset edge.
  assign ld_acc = ld_valid & ld_ready & ~reset;
  assign fe_acc = fe_req & fe_ready & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      wptr_q     <= '0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rd_valid_q <= fe_acc;
      misalign_q <= fe_acc & (ra[1:0] != 2'b00);
      if (ld_acc) begin
        if (wptr_q != WLAST) begin
          wptr_q <= wptr_q + 1'b1;
        end
        if (ld_last || (wptr_q == WLAST)) begin
          state_q <= RUN;
        end
      end
    end
  end

  imem_array #(
    .AW (WAW),
    .W  (INS_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ld_acc),
    .waddr_i (wptr_q),
    .wdata_i (ld_data),
    .re_i    (fe_acc),
    .rzero_i (ra[1:0] != 2'b00),
    .raddr_i (ra[INS_ADDRESS-1:2]),
    .rdata_o (rd),
    .perr_o  (perr)
  );

  assign rd_valid = rd_valid_q;
  assign fault    = rd_valid_q & (misalign_q | perr);

endmodule

`default_nettype wire

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: expected fetch responses queue up as
// fetches are issued and are matched against rd/fault on each falling edge.
`default_nettype none

module tb_imem_loadable;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        fe_req;
  logic [8:0]  ra;
  logic        fe_ready;
  logic [31:0] rd;
  logic        rd_valid;
  logic        fault;

  typedef struct packed {
    logic [31:0] rd;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [128];
  int          mwptr;
  bit          mrun;
  int          n_checks = 0;
  int          n_fail   = 0;

  imem_loadable #(
    .INS_ADDRESS (9),
    .INS_W       (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .fe_req   (fe_req),
    .ra       (ra),
    .fe_ready (fe_ready),
    .rd       (rd),
    .rd_valid (rd_valid),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model[i] = 32'h0;
    mwptr = 0;
    mrun  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (!mrun) begin
      model[mwptr] = d;
      if (last || mwptr == 127) mrun = 1'b1;
      else mwptr++;
    end
  endtask

  task automatic fetch(input logic [8:0] a);
    exp_t e;
    fe_req = 1'b1;
    ra     = a;
    step();
    fe_req = 1'b0;
    if (a[1:0] != 2'b00) e = '{rd: 32'h0, fault: 1'b1};
    else                 e = '{rd: model[a[8:2]], fault: 1'b0};
    sb.push_back(e);
  endtask

  // Response checker: every accepted fetch must answer on the next falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_valid", 32'(rd_valid), 32'd1);
      if (rd_valid) begin
        chk("rd", rd, e.rd);
        chk("fault", 32'(fault), 32'(e.fault));
      end
    end else begin
      chk("rd_valid_idle", 32'(rd_valid), 32'd0);
      chk("fault_idle", 32'(fault), 32'd0);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    ld_valid = 1'b0;
    ld_data  = 32'h0;
    ld_last  = 1'b0;
    fe_req   = 1'b0;
    ra       = 9'h0;
    model_reset();

    step();
    step();
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_fe_ready", 32'(fe_ready), 32'd0);
    chk("rst_rd", rd, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;

    // Fetch requests held during LOAD must be ignored.
    fe_req = 1'b1;
    ra     = 9'd0;
    load_word(32'h00100093, 1'b0);
    chk("load_fe_ready", 32'(fe_ready), 32'd0);
    chk("load_ld_ready", 32'(ld_ready), 32'd1);
    load_word(32'h00200113, 1'b1);
    fe_req = 1'b0;
    chk("run_ld_ready", 32'(ld_ready), 32'd0);
    chk("run_fe_ready", 32'(fe_ready), 32'd1);

    // Load traffic in RUN is ignored; word 2 must stay empty.
    load_word(32'hDEADBEEF, 1'b1);

    fetch(9'd4);
    step();
    chk("hold_rd", rd, 32'h00200113);

    fetch(9'd0);
    fetch(9'd4);
    fetch(9'd8);
    step();

    fetch(9'd6);
    step();
    chk("hold_after_fault", rd, 32'h0);

    // A fetch coinciding with reset is aborted.
    fe_req = 1'b1;
    ra     = 9'd0;
    do_reset();
    fe_req = 1'b0;
    chk("abort_ld_ready", 32'(ld_ready), 32'd1);
    chk("abort_rd", rd, 32'h0);

    // Full fill without ld_last: switches to RUN only after the last word.
    for (int i = 0; i < 128; i++) begin
      load_word({8'hA5, 8'(i), 8'(~i), 8'(i * 3)}, 1'b0);
      if (i == 126) chk("fill_still_load", 32'(ld_ready), 32'd1);
    end
    chk("fill_run", 32'(fe_ready), 32'd1);
    fetch(9'd508);
    fetch(9'd0);
    fetch(9'd256);
    fetch(9'd509);
    step();

    // Reset mid-load, asserted together with a load offer.
    do_reset();
    load_word(32'h11111111, 1'b0);
    load_word(32'h22222222, 1'b0);
    load_word(32'h33333333, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 32'h44444444;
    do_reset();
    ld_valid = 1'b0;
    chk("midload_ld_ready", 32'(ld_ready), 32'd1);
    chk("midload_fe_ready", 32'(fe_ready), 32'd0);
    load_word(32'hCAFEF00D, 1'b1);
    fetch(9'd0);
    fetch(9'd4);
    fetch(9'd8);
    step();
    step();

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
